// File: rtl/regfile_op_sequencer.sv
// Register-transfer instruction sequencer for an 8x8 register file with one read port.
// Operands are read one per cycle, then a single write-back cycle commits the result.
module regfile_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_WB,
        S_DONE_NOP
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    state_t              state_reg;
    logic [2:0]          op_reg;
    logic [ADDR_W-1:0]   rd_reg;
    logic [ADDR_W-1:0]   rs2_reg;
    logic [DATA_W-1:0]   op_a_reg;
    logic                flag_z_pend_reg;
    logic                flag_c_pend_reg;
    logic [ADDR_W-1:0]   rf_raddr_reg;
    logic [ADDR_W-1:0]   rf_waddr_reg;
    logic [DATA_W-1:0]   rf_wdata_reg;
    logic                rf_we_reg;
    logic                done_reg;
    logic                flag_z_reg;
    logic                flag_c_reg;

    logic [DATA_W:0]     sum_ext;
    logic [DATA_W:0]     diff_ext;
    logic [DATA_W-1:0]   alu_result_next;
    logic                alu_c_next;
    logic                alu_z_next;

    // Second operand comes straight off the read port during RD_B.
    assign sum_ext  = {1'b0, op_a_reg} + {1'b0, rf_rdata};
    assign diff_ext = {1'b0, op_a_reg} - {1'b0, rf_rdata};

    always_comb begin
        alu_result_next = '0;
        alu_c_next      = 1'b0;
        case (op_reg)
            OP_ADD: begin
                alu_result_next = sum_ext[DATA_W-1:0];
                alu_c_next      = sum_ext[DATA_W];
            end
            OP_SUB: begin
                alu_result_next = diff_ext[DATA_W-1:0];
                alu_c_next      = diff_ext[DATA_W];
            end
            OP_AND:  alu_result_next = op_a_reg & rf_rdata;
            OP_OR:   alu_result_next = op_a_reg | rf_rdata;
            OP_XOR:  alu_result_next = op_a_reg ^ rf_rdata;
            default: alu_result_next = '0;
        endcase
        alu_z_next = (alu_result_next == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            op_reg          <= OP_NOP;
            rd_reg          <= '0;
            rs2_reg         <= '0;
            op_a_reg        <= '0;
            flag_z_pend_reg <= 1'b0;
            flag_c_pend_reg <= 1'b0;
            rf_raddr_reg    <= '0;
            rf_waddr_reg    <= '0;
            rf_wdata_reg    <= '0;
            rf_we_reg       <= 1'b0;
            done_reg        <= 1'b0;
            flag_z_reg      <= 1'b0;
            flag_c_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_reg  <= instr[15:13];
                        rd_reg  <= instr[12:10];
                        rs2_reg <= instr[6:4];
                        case (instr[15:13])
                            OP_NOP: begin
                                state_reg <= S_DONE_NOP;
                                done_reg  <= 1'b1;
                            end
                            OP_LDI: begin
                                state_reg    <= S_WB;
                                rf_we_reg    <= 1'b1;
                                rf_waddr_reg <= instr[12:10];
                                rf_wdata_reg <= instr[7:0];
                                done_reg     <= 1'b1;
                            end
                            default: begin
                                state_reg    <= S_RD_A;
                                rf_raddr_reg <= instr[9:7];
                            end
                        endcase
                    end
                end
                S_RD_A: begin
                    op_a_reg <= rf_rdata;
                    if (op_reg == OP_MOV) begin
                        state_reg    <= S_WB;
                        rf_raddr_reg <= '0;
                        rf_we_reg    <= 1'b1;
                        rf_waddr_reg <= rd_reg;
                        rf_wdata_reg <= rf_rdata;
                        done_reg     <= 1'b1;
                    end else begin
                        state_reg    <= S_RD_B;
                        rf_raddr_reg <= rs2_reg;
                    end
                end
                S_RD_B: begin
                    state_reg       <= S_WB;
                    flag_z_pend_reg <= alu_z_next;
                    flag_c_pend_reg <= alu_c_next;
                    rf_raddr_reg    <= '0;
                    rf_we_reg       <= 1'b1;
                    rf_waddr_reg    <= rd_reg;
                    rf_wdata_reg    <= alu_result_next;
                    done_reg        <= 1'b1;
                end
                S_WB: begin
                    // Flags become visible only once the ALU write-back has committed.
                    if (op_reg >= OP_ADD) begin
                        flag_z_reg <= flag_z_pend_reg;
                        flag_c_reg <= flag_c_pend_reg;
                    end
                    state_reg    <= S_IDLE;
                    rf_we_reg    <= 1'b0;
                    rf_waddr_reg <= '0;
                    rf_wdata_reg <= '0;
                    done_reg     <= 1'b0;
                end
                S_DONE_NOP: begin
                    state_reg <= S_IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    rf_we_reg <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Held low for the whole time reset is asserted, not just until the next edge.
    assign instr_ready = (state_reg == S_IDLE) && !reset;
    assign rf_raddr    = rf_raddr_reg;
    assign rf_waddr    = rf_waddr_reg;
    assign rf_wdata    = rf_wdata_reg;
    assign rf_we       = rf_we_reg;
    assign done        = done_reg;
    assign flag_z      = flag_z_reg;
    assign flag_c      = flag_c_reg;

endmodule
